// File: rtl/gfx_cmd_pkg.sv
// Shared types and constants for the command dispatcher: opcodes, FSM states,
// error codes, header layout and header validation.
package gfx_cmd_pkg;

  localparam logic [7:0] OP_NOP          = 8'h00;
  localparam logic [7:0] OP_CLEAR        = 8'h01;
  localparam logic [7:0] OP_DRAW_TRI     = 8'h02;
  localparam logic [7:0] OP_SIMD         = 8'h03;
  localparam logic [7:0] OP_SET_COLOR    = 8'h10;
  localparam logic [7:0] OP_SET_VIEWPORT = 8'h11;

  localparam logic [15:0] LEN_NOP          = 16'd0;
  localparam logic [15:0] LEN_CLEAR        = 16'd0;
  localparam logic [15:0] LEN_DRAW_TRI     = 16'd6;
  localparam logic [15:0] LEN_SET_COLOR    = 16'd1;
  localparam logic [15:0] LEN_SET_VIEWPORT = 16'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARGS,
    ST_EXEC,
    ST_DISPATCH,
    ST_WAIT_DONE,
    ST_DRAIN,
    ST_ERROR
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_UNKNOWN_OP   = 3'd1,
    ERR_LEN_MISMATCH = 3'd2,
    ERR_LEN_OVERFLOW = 3'd3,
    ERR_TIMEOUT      = 3'd4
  } err_e;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  flags;
    logic [15:0] length;
  } cmd_hdr_t;

  // Classify a header; checks are ordered unknown opcode, overflow, mismatch.
  function automatic err_e hdr_check(input cmd_hdr_t h, input int num_units, input int max_args);
    logic        known;
    logic        len_ok;
    logic [15:0] exp_len;
    known   = 1'b1;
    exp_len = '0;
    case (h.opcode)
      OP_NOP:          exp_len = LEN_NOP;
      OP_CLEAR:        begin exp_len = LEN_CLEAR;    known = (num_units >= 1); end
      OP_DRAW_TRI:     begin exp_len = LEN_DRAW_TRI; known = (num_units >= 2); end
      OP_SIMD:         known = (num_units >= 3);
      OP_SET_COLOR:    exp_len = LEN_SET_COLOR;
      OP_SET_VIEWPORT: exp_len = LEN_SET_VIEWPORT;
      default:         known = 1'b0;
    endcase
    len_ok = (h.opcode == OP_SIMD) ? (h.length != 16'd0) : (h.length == exp_len);
    if (!known)                      return ERR_UNKNOWN_OP;
    if (int'(h.length) > max_args)   return ERR_LEN_OVERFLOW;
    if (!len_ok)                     return ERR_LEN_MISMATCH;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/cmd_arg_buffer.sv
// Argument word store: indexed write, synchronous clear, flat read-out with
// word k in bits [32k+31:32k].
module cmd_arg_buffer #(
  parameter int MAX_ARGS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [15:0]            wr_idx,
  input  logic [31:0]            wr_data,
  output logic [32*MAX_ARGS-1:0] args
);

  logic [MAX_ARGS-1:0][31:0] buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (clr) begin
      buf_d = '0;
    end else if (wr_en) begin
      for (int k = 0; k < MAX_ARGS; k++)
        if (wr_idx == 16'(k)) buf_d[k] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) buf_q <= '0;
    else     buf_q <= buf_d;
  end

  assign args = buf_q;

endmodule

// File: rtl/command_dispatcher.sv
// Decodes a header/payload word stream, updates colour/viewport state or
// dispatches to one of NUM_UNITS engines with a start/done handshake and watchdog.
module command_dispatcher
  import gfx_cmd_pkg::*;
#(
  parameter int NUM_UNITS      = 3,
  parameter int MAX_ARGS       = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [31:0]            cmd_data,
  output logic                   cmd_ready,
  output logic [NUM_UNITS-1:0]   unit_start,
  input  logic [NUM_UNITS-1:0]   unit_done,
  output logic [32*MAX_ARGS-1:0] unit_args,
  output logic [15:0]            unit_argc,
  output logic [7:0]             unit_flags,
  output logic [31:0]            color_reg,
  output logic [127:0]           viewport,
  output logic                   busy,
  output logic                   err_valid,
  output logic [2:0]             err_code
);

  localparam bit          WD_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] WD_LAST = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_e                 state_q, state_d;
  cmd_hdr_t               hdr_q, hdr_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [31:0]            wd_q, wd_d;
  err_e                   pend_err_q, pend_err_d;
  logic [NUM_UNITS-1:0]   start_q, start_d;
  logic [15:0]            argc_q, argc_d;
  logic [7:0]             flags_q, flags_d;
  logic [31:0]            color_q, color_d;
  logic [127:0]           vp_q, vp_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   err_valid_q, err_valid_d;
  err_e                   err_code_q, err_code_d;

  logic                   accept;
  cmd_hdr_t               hdr_in;
  err_e                   hdr_err;
  logic [15:0]            cnt_inc;
  logic                   buf_clr, buf_wr;
  logic [32*MAX_ARGS-1:0] args_flat;
  logic [NUM_UNITS-1:0]   unit_sel;

  assign accept  = cmd_valid & ready_q;
  assign hdr_in  = cmd_hdr_t'(cmd_data);
  assign hdr_err = hdr_check(hdr_in, NUM_UNITS, MAX_ARGS);
  assign cnt_inc = cnt_q + 16'd1;

  // Unit i serves opcode i+1; only meaningful once the header is known valid.
  always_comb begin
    unit_sel = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      unit_sel[i] = (hdr_q.opcode == 8'(i + 1));
  end

  cmd_arg_buffer #(.MAX_ARGS(MAX_ARGS)) u_args (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_idx  (cnt_q),
    .wr_data (cmd_data),
    .args    (args_flat)
  );

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    pend_err_d  = pend_err_q;
    start_d     = '0;
    argc_d      = argc_q;
    flags_d     = flags_q;
    color_d     = color_q;
    vp_d        = vp_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    buf_clr     = 1'b0;
    buf_wr      = 1'b0;

    case (state_q)
      ST_IDLE: if (accept) begin
        hdr_d      = hdr_in;
        cnt_d      = '0;
        buf_clr    = 1'b1;
        pend_err_d = hdr_err;
        if (hdr_err != ERR_NONE)
          state_d = (hdr_in.length != 16'd0) ? ST_DRAIN : ST_ERROR;
        else
          state_d = (hdr_in.length == 16'd0) ? ST_EXEC : ST_ARGS;
      end
      ST_ARGS: if (accept) begin
        buf_wr = 1'b1;
        cnt_d  = cnt_inc;
        if (cnt_inc == hdr_q.length) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (hdr_q.opcode)
          OP_SET_COLOR:    color_d = args_flat[31:0];
          OP_SET_VIEWPORT: vp_d    = 128'(args_flat);
          default:         ;
        endcase
        if (hdr_q.opcode inside {OP_NOP, OP_SET_COLOR, OP_SET_VIEWPORT}) begin
          state_d = ST_IDLE;
        end else begin
          start_d = unit_sel;
          argc_d  = hdr_q.length;
          flags_d = hdr_q.flags;
          state_d = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        wd_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (|(unit_done & unit_sel)) begin
          state_d = ST_IDLE;
        end else if (WD_EN && wd_q == WD_LAST) begin
          pend_err_d = ERR_TIMEOUT;
          state_d    = ST_ERROR;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      ST_DRAIN: if (accept) begin
        cnt_d = cnt_inc;
        if (cnt_inc == hdr_q.length) state_d = ST_ERROR;
      end
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // ERROR always lasts one cycle, so entering it is exactly the pulse cycle.
    if (state_d == ST_ERROR) begin
      err_valid_d = 1'b1;
      err_code_d  = pend_err_d;
    end
  end

  assign ready_d = (state_d == ST_IDLE) || (state_d == ST_ARGS) || (state_d == ST_DRAIN);
  assign busy_d  = (state_d != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      pend_err_q  <= ERR_NONE;
      start_q     <= '0;
      argc_q      <= '0;
      flags_q     <= '0;
      color_q     <= '0;
      vp_q        <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      pend_err_q  <= pend_err_d;
      start_q     <= start_d;
      argc_q      <= argc_d;
      flags_q     <= flags_d;
      color_q     <= color_d;
      vp_q        <= vp_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign unit_start = start_q;
  assign unit_args  = args_flat;
  assign unit_argc  = argc_q;
  assign unit_flags = flags_q;
  assign color_reg  = color_q;
  assign viewport   = vp_q;
  assign busy       = busy_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_command_dispatcher.sv
// Directed plus randomized command streams checked against a command-level
// outcome model (state update, dispatch to unit, or error code).
module tb_command_dispatcher;

  localparam int NU = 3;
  localparam int MA = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic [31:0]       cmd_data;
  logic              cmd_ready;
  logic [NU-1:0]     unit_start;
  logic [NU-1:0]     unit_done;
  logic [32*MA-1:0]  unit_args;
  logic [15:0]       unit_argc;
  logic [7:0]        unit_flags;
  logic [31:0]       color_reg;
  logic [127:0]      viewport;
  logic              busy;
  logic              err_valid;
  logic [2:0]        err_code;

  always #5 clk = ~clk;

  command_dispatcher #(.NUM_UNITS(NU), .MAX_ARGS(MA), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .unit_start(unit_start), .unit_done(unit_done), .unit_args(unit_args),
    .unit_argc(unit_argc), .unit_flags(unit_flags), .color_reg(color_reg),
    .viewport(viewport), .busy(busy), .err_valid(err_valid), .err_code(err_code)
  );

  int checks = 0, failures = 0;
  int start_cnt = 0, bad_onehot = 0;

  // Sees the pre-edge value of unit_start: one count per start cycle.
  always @(posedge clk) begin
    if (unit_start != '0) start_cnt <= start_cnt + 1;
    if (unit_start != '0 && !$onehot(unit_start)) bad_onehot <= bad_onehot + 1;
  end

  logic [31:0]  wbuf [0:15];
  logic [31:0]  m_color;
  logic [127:0] m_vp;
  int           m_err;
  bit           stalls;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // kind: 0 = state update / nop, 1 = dispatch to unit val, 2 = error code val
  task automatic predict(input logic [31:0] hdr, output int kind, output int val);
    int op, len, need;
    bit known, is_unit;
    op = int'(hdr[31:24]); len = int'(hdr[15:0]);
    known = 1; is_unit = 0; need = 0;
    case (op)
      'h00: need = 0;
      'h01: begin need = 0; is_unit = 1; end
      'h02: begin need = 6; is_unit = 1; end
      'h03: begin need = -1; is_unit = 1; end
      'h10: need = 1;
      'h11: need = 4;
      default: known = 0;
    endcase
    if (is_unit && op > NU) known = 0;
    kind = 0; val = 0;
    if (!known)                                 begin kind = 2; val = 1; end
    else if (len > MA)                          begin kind = 2; val = 3; end
    else if (need < 0 ? (len == 0) : (len != need)) begin kind = 2; val = 2; end
    else if (is_unit)                           begin kind = 1; val = op - 1; end
    else if (op == 'h10) m_color = wbuf[0];
    else if (op == 'h11) m_vp = {wbuf[3], wbuf[2], wbuf[1], wbuf[0]};
  endtask

  task automatic send_word(input logic [31:0] w);
    bit ok = 0;
    if (stalls && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = w;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (cmd_ready) begin @(posedge clk); ok = 1; end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("accept", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (!busy) ok = 1;
      else @(negedge clk);
    end
    chk("idle", ok, 1);
  endtask

  task automatic do_cmd(input logic [31:0] hdr, input int nw);
    int kind, val, s0, len;
    bit seen;
    predict(hdr, kind, val);
    len = int'(hdr[15:0]);
    s0  = start_cnt;
    send_word(hdr);
    for (int i = 0; i < nw; i++) send_word(wbuf[i]);
    seen = 0;
    if (kind == 2) begin
      for (int n = 0; n < 50 && !seen; n++) begin
        if (err_valid) seen = 1; else @(negedge clk);
      end
      chk("err_seen", seen, 1);
      if (seen) chk("err_code", err_code, val);
      m_err = val;
    end else if (kind == 1) begin
      for (int n = 0; n < 50 && !seen; n++) begin
        if (unit_start != '0) seen = 1; else @(negedge clk);
      end
      chk("start_seen", seen, 1);
      if (seen) begin
        chk("start", unit_start, 1 << val);
        chk("argc", unit_argc, len);
        chk("flags", unit_flags, hdr[23:16]);
        for (int k = 0; k < len; k++) chk("arg", unit_args[32*k +: 32], wbuf[k]);
        @(negedge clk);
        chk("start_1cyc", unit_start, 0);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
          unit_done = NU'(1 << ((val + 1) % NU));
          @(negedge clk);
          unit_done = '0;
          chk("stray_busy", busy, 1);
        end
        unit_done = NU'(1 << val);
        @(negedge clk);
        unit_done = '0;
        chk("done_idle", busy, 0);
      end
    end
    wait_idle();
    chk("start_count", start_cnt - s0, (kind == 1) ? 1 : 0);
    chk("color", color_reg, m_color);
    chk("viewport", viewport, m_vp);
    chk("err_hold", err_code, m_err);
  endtask

  initial begin
    int s0, r, op, len;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; unit_done = '0;
    m_color = '0; m_vp = '0; m_err = 0; stalls = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", unit_start, 0);
    chk("rst_errv", err_valid, 0);
    chk("rst_code", err_code, 0);
    chk("rst_argc", unit_argc, 0);
    chk("rst_color", color_reg, 0);
    chk("rst_vp", viewport, 0);
    rst = 1'b0;
    @(negedge clk);

    // viewport and colour
    wbuf[0] = 0; wbuf[1] = 0; wbuf[2] = 4; wbuf[3] = 3;
    do_cmd(32'h1100_0004, 4);
    chk("vp_direct", viewport, {32'd3, 32'd4, 32'd0, 32'd0});
    wbuf[0] = 32'h00FF_0000;
    do_cmd(32'h1000_0001, 1);
    chk("color_direct", color_reg, 32'h00FF_0000);

    // triangle dispatch
    wbuf[0] = 10; wbuf[1] = 10; wbuf[2] = 50; wbuf[3] = 10; wbuf[4] = 30; wbuf[5] = 40;
    do_cmd(32'h0200_0006, 6);

    // CLEAR timing, stray done on another unit
    send_word(32'h0100_0000);
    chk("clr_early", unit_start, 0);
    @(negedge clk);
    chk("clr_start", unit_start, 3'b001);
    @(negedge clk);
    unit_done = 3'b010;
    @(negedge clk);
    unit_done = '0;
    chk("clr_stray", busy, 1);
    unit_done = 3'b001;
    @(negedge clk);
    unit_done = '0;
    chk("clr_done", busy, 0);

    // length mismatch, unknown opcode, overflow drain, then a good command
    wbuf[0] = 1; wbuf[1] = 2; wbuf[2] = 3;
    do_cmd(32'h0200_0003, 3);
    do_cmd(32'h7F00_0002, 2);
    for (int i = 0; i < 9; i++) wbuf[i] = $urandom;
    do_cmd(32'h0300_0009, 9);
    wbuf[0] = 32'h1234_5678;
    do_cmd(32'h1000_0001, 1);

    // watchdog: SIMD with no done
    s0 = start_cnt;
    wbuf[0] = 32'hA; wbuf[1] = 32'hB;
    send_word(32'h0300_0002);
    send_word(wbuf[0]);
    send_word(wbuf[1]);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (i == 17) chk("to_early", err_valid, 0);
      if (i == 18) begin chk("to_fire", err_valid, 1); chk("to_code", err_code, 4); end
      if (i == 19) chk("to_pulse", err_valid, 0);
    end
    m_err = 4;
    chk("to_started", start_cnt - s0, 1);
    wait_idle();

    // reset in the middle of a payload
    send_word(32'h0200_0006);
    send_word(32'h1);
    send_word(32'h2);
    s0 = start_cnt;
    rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_ready", cmd_ready, 0);
    chk("mid_color", color_reg, 0);
    chk("mid_vp", viewport, 0);
    chk("mid_code", err_code, 0);
    chk("mid_args", unit_args[127:0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_color = '0; m_vp = '0; m_err = 0;
    repeat (10) @(negedge clk);
    chk("mid_nostart", start_cnt - s0, 0);
    chk("mid_idle", busy, 0);

    // randomized command mix with input stalls
    stalls = 1;
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 7);
      case (r)
        0: begin op = 'h00; len = 0; end
        1: begin op = 'h01; len = 0; end
        2: begin op = 'h02; len = 6; end
        3: begin op = 'h03; len = $urandom_range(1, MA); end
        4: begin op = 'h10; len = 1; end
        5: begin op = 'h11; len = 4; end
        6: begin op = $urandom_range(4, 15); len = $urandom_range(0, 3); end
        default: begin op = $urandom_range(32, 255); len = $urandom_range(0, 3); end
      endcase
      if ($urandom_range(0, 3) == 0) len = $urandom_range(0, 11);
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      do_cmd({8'(op), 8'($urandom_range(0, 255)), 16'(len)}, len);
    end

    chk("onehot", bad_onehot, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
